cache_wb_mem: RTL and testbench
===============================

Name: cache_wb_mem

Overview:
- Write-back side of the cache/SRAM memory path: takes one dirty DCache line (address plus full line) and writes it word by word into base or ext SRAM.
- Drives SRAM control and the write data bus; a read-refill controller owns the same SRAM pins when this block is not granted.
- Bus ownership uses a req/grant pair; the line handshake uses valid/ready in the same style as the refill interface.

Parameters:
- WORD, 32, data/address word width
- CACHE_LINE_WIDTH, 128, line width; words per line WPL = CACHE_LINE_WIDTH/WORD (power of 2, >=2)
- WRITE_WAIT_CYCLE, 2, cycles we_n held low per word (>=1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_valid_from_DCache  in  1  write-back request; held high until ready pulse
- wb_addr  in  WORD  line base address (low log2(CACHE_LINE_WIDTH/8) bits ignored)
- wb_line  in  CACHE_LINE_WIDTH  line data; word i = bits [WORD*i +: WORD]
- memory_ready_for_DCache_wb  out  1  one-cycle pulse: line fully written
- bus_req  out  1  requests SRAM pin ownership
- bus_grant  in  1  ownership granted by arbiter
- base_ram_ce_n / base_ram_oe_n / base_ram_we_n  out  1 each  base SRAM control
- ext_ram_ce_n / ext_ram_oe_n / ext_ram_we_n  out  1 each  ext SRAM control
- ram_addr  out  20  SRAM word address = addr[21:2]
- ram_be_n  out  4  byte enables, active low; 4'b0000 while writing
- ram_wdata  out  WORD  write data
- ram_wdata_oe  out  1  top-level tristate enable for the selected SRAM data bus

Behaviour:
- Reset / idle outputs: all ce_n/oe_n/we_n = 1, ram_be_n = 4'hF, ram_wdata_oe = 0, bus_req = 0, ready = 0, ram_addr = 0, ram_wdata = 0, state IDLE, word counter 0.
- Bank select is latched from the line address: bit 22 = 0 -> base, 1 -> ext. Only the selected bank's ce_n/we_n go low. oe_n stays 1 throughout.
- States:
  - IDLE: bus_req = wb_valid. On wb_valid & bus_grant, latch addr, line and bank; cnt = 0; -> SETUP.
  - SETUP (1 cycle): ce_n = 0, we_n = 1, ram_addr = line_addr + cnt, ram_wdata = word[cnt], oe = 1 -> WRITE.
  - WRITE (WRITE_WAIT_CYCLE cycles, counted by wait_cnt): we_n = 0, address/data stable -> HOLD.
  - HOLD (1 cycle): we_n = 1, ce_n = 0, data still driven. If cnt == WPL-1 -> DONE, else cnt++ -> SETUP.
  - DONE (1 cycle): ready = 1, ce_n = 1, oe = 0, bus_req = 0 -> IDLE.
- bus_req stays 1 from acceptance through HOLD of the last word.
- Latency: acceptance cycle to ready pulse = WPL*(WRITE_WAIT_CYCLE+2)+1 cycles, i.e. 17 with defaults.
- Address and data never change while we_n = 0 (setup/hold guaranteed by SETUP/HOLD).
- Address increment wraps within 20 bits; cnt never crosses the line boundary.
- bus_grant deasserting mid-line is ignored; the arbiter must not revoke grant before DONE.
- wb_valid held high across DONE: no new accept in DONE. IDLE may accept it again in the following cycle, so the DCache must drop valid on the ready pulse.
- wb_addr/wb_line changes after acceptance have no effect (latched copy used).
- rst in any state returns to IDLE with reset outputs on the next edge; the partial line is abandoned and no ready pulse is issued.

Decomposition:
- CPU_Parameter.vh: WORD, CACHE_LINE_WIDTH, WRITE_WAIT_CYCLE, bank-select bit index (22), state encodings.
- Optional sub-module sram_write_timer: wait_cnt counter with start/done.

Test Plan:
- Reset: rst=1 for 2 cycles mid-WRITE -> next cycle all ce_n/we_n = 1, bus_req = 0, ram_wdata_oe = 0, no ready pulse.
- Base write: wb_addr = 0x8000_0010, line = {0x44444444, 0x33333333, 0x22222222, 0x11111111}, grant = 1 -> base writes at addr 0x00004..0x00007 with data 0x11111111..0x44444444; ext_ram_ce_n stays 1; ready pulse exactly 17 cycles after accept.
- Ext write: wb_addr = 0x8040_0000 -> ext bank, ram_addr 0x00000..0x00003; base_ram_ce_n stays 1.
- Grant delay: valid = 1, grant = 0 for 5 cycles -> bus_req = 1, no strobes; grant = 1 -> accept on that cycle.
- Timing check: each word has we_n low for exactly 2 cycles with addr/data stable one cycle before and one cycle after.
- Back-to-back: valid dropped on ready, reasserted next cycle with a new line -> second line written correctly with no stray strobe between the lines.

Source files
------------

// File: rtl/cache_wb_mem_pkg.sv
// rtl/cache_wb_mem_pkg.sv - shared constants, state encoding and address helper for the line write-back path
package cache_wb_mem_pkg;

    localparam int DEF_WORD             = 32;
    localparam int DEF_CACHE_LINE_WIDTH = 128;
    localparam int DEF_WRITE_WAIT_CYCLE = 2;
    localparam int BANK_SEL_BIT         = 22;
    localparam int RAM_ADDR_W           = 20;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_WRITE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } wb_state_e;

    // Clears the word-within-line bits so the burst always starts on the line boundary.
    function automatic logic [RAM_ADDR_W-1:0] line_base(input logic [RAM_ADDR_W-1:0] word_addr,
                                                        input int unsigned wpl);
        return word_addr & ~RAM_ADDR_W'(wpl - 1);
    endfunction

endpackage

// File: rtl/cache_wb_mem_timer.sv
// rtl/cache_wb_mem_timer.sv - counts the cycles we_n is held low for one word
module cache_wb_mem_timer #(
    parameter int WAIT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic done
);

    localparam int CW = $clog2(WAIT + 1);

    logic [CW-1:0] wait_cnt;

    assign done = en && (wait_cnt == CW'(WAIT - 1));

    always_ff @(posedge clk) begin
        if (rst || !en || done) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_wb_mem.sv
// rtl/cache_wb_mem.sv - writes one dirty DCache line word by word into base or ext SRAM
module cache_wb_mem
    import cache_wb_mem_pkg::*;
#(
    parameter int WORD             = DEF_WORD,
    parameter int CACHE_LINE_WIDTH = DEF_CACHE_LINE_WIDTH,
    parameter int WRITE_WAIT_CYCLE = DEF_WRITE_WAIT_CYCLE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wb_valid_from_DCache,
    input  logic [WORD-1:0]             wb_addr,
    input  logic [CACHE_LINE_WIDTH-1:0] wb_line,
    output logic                        memory_ready_for_DCache_wb,
    output logic                        bus_req,
    input  logic                        bus_grant,
    output logic                        base_ram_ce_n,
    output logic                        base_ram_oe_n,
    output logic                        base_ram_we_n,
    output logic                        ext_ram_ce_n,
    output logic                        ext_ram_oe_n,
    output logic                        ext_ram_we_n,
    output logic [19:0]                 ram_addr,
    output logic [3:0]                  ram_be_n,
    output logic [WORD-1:0]             ram_wdata,
    output logic                        ram_wdata_oe
);

    localparam int WPL   = CACHE_LINE_WIDTH / WORD;
    localparam int CNT_W = $clog2(WPL);

    wb_state_e                   state, state_next;
    logic [CNT_W-1:0]            cnt;
    logic [RAM_ADDR_W-1:0]       line_addr;
    logic [CACHE_LINE_WIDTH-1:0] line_q;
    logic                        bank_ext;
    logic                        accept;
    logic                        last_word;
    logic                        wait_done;
    logic [RAM_ADDR_W-1:0]       word_addr;
    logic [WORD-1:0]             word_data;
    logic                        unused_addr_bits;

    assign accept    = (state == ST_IDLE) && wb_valid_from_DCache && bus_grant;
    assign last_word = (cnt == CNT_W'(WPL - 1));
    assign word_addr = line_addr + RAM_ADDR_W'(cnt);
    assign word_data = line_q[cnt*WORD +: WORD];

    // Byte offset and bits above the bank select never reach the SRAM.
    assign unused_addr_bits = ^{wb_addr[WORD-1:BANK_SEL_BIT+1], wb_addr[1:0]};

    cache_wb_mem_timer #(
        .WAIT (WRITE_WAIT_CYCLE)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_WRITE),
        .done (wait_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            line_addr <= '0;
            line_q    <= '0;
            bank_ext  <= 1'b0;
        end else if (accept) begin
            cnt       <= '0;
            line_addr <= line_base(wb_addr[RAM_ADDR_W+1:2], WPL);
            line_q    <= wb_line;
            bank_ext  <= wb_addr[BANK_SEL_BIT];
        end else if (state == ST_HOLD && !last_word) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (accept) state_next = ST_SETUP;
            ST_SETUP: state_next = ST_WRITE;
            ST_WRITE: if (wait_done) state_next = ST_HOLD;
            ST_HOLD:  state_next = last_word ? ST_DONE : ST_SETUP;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Address and data come straight from latched registers, so they cannot move while we_n is low.
    always_comb begin
        memory_ready_for_DCache_wb = 1'b0;
        bus_req                    = 1'b0;
        base_ram_ce_n              = 1'b1;
        base_ram_oe_n              = 1'b1;
        base_ram_we_n              = 1'b1;
        ext_ram_ce_n               = 1'b1;
        ext_ram_oe_n               = 1'b1;
        ext_ram_we_n               = 1'b1;
        ram_addr                   = '0;
        ram_be_n                   = 4'hF;
        ram_wdata                  = '0;
        ram_wdata_oe               = 1'b0;
        unique case (state)
            ST_IDLE: bus_req = wb_valid_from_DCache;
            ST_SETUP, ST_WRITE, ST_HOLD: begin
                bus_req      = 1'b1;
                ram_addr     = word_addr;
                ram_wdata    = word_data;
                ram_be_n     = 4'h0;
                ram_wdata_oe = 1'b1;
                if (bank_ext) begin
                    ext_ram_ce_n = 1'b0;
                    ext_ram_we_n = (state != ST_WRITE);
                end else begin
                    base_ram_ce_n = 1'b0;
                    base_ram_we_n = (state != ST_WRITE);
                end
            end
            ST_DONE: memory_ready_for_DCache_wb = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cache_wb_mem.sv
// tb/tb_cache_wb_mem.sv - self-checking bench for cache_wb_mem
module tb_cache_wb_mem;

    localparam int WPL = 4;
    localparam int WWC = 2;
    localparam int LAT = WPL * (WWC + 2) + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         wb_valid;
    logic [31:0]  wb_addr;
    logic [127:0] wb_line;
    logic         ready;
    logic         bus_req;
    logic         bus_grant;
    logic         base_ram_ce_n, base_ram_oe_n, base_ram_we_n;
    logic         ext_ram_ce_n, ext_ram_oe_n, ext_ram_we_n;
    logic [19:0]  ram_addr;
    logic [3:0]   ram_be_n;
    logic [31:0]  ram_wdata;
    logic         ram_wdata_oe;

    cache_wb_mem dut (
        .clk                        (clk),
        .rst                        (rst),
        .wb_valid_from_DCache       (wb_valid),
        .wb_addr                    (wb_addr),
        .wb_line                    (wb_line),
        .memory_ready_for_DCache_wb (ready),
        .bus_req                    (bus_req),
        .bus_grant                  (bus_grant),
        .base_ram_ce_n              (base_ram_ce_n),
        .base_ram_oe_n              (base_ram_oe_n),
        .base_ram_we_n              (base_ram_we_n),
        .ext_ram_ce_n               (ext_ram_ce_n),
        .ext_ram_oe_n               (ext_ram_oe_n),
        .ext_ram_we_n               (ext_ram_we_n),
        .ram_addr                   (ram_addr),
        .ram_be_n                   (ram_be_n),
        .ram_wdata                  (ram_wdata),
        .ram_wdata_oe               (ram_wdata_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        bank;
        logic [19:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] line;
        int           gdelay;
        logic         exp_bank;
        logic [19:0]  exp_base;
    } vec_t;

    wr_t got_q[$];
    int  ce_b_cnt, ce_e_cnt, ready_cnt;

    // Monitor: turns we_n pulses into write records and checks setup/hold around each one.
    logic        p_ok, p_ceb, p_web, p_cee, p_wee, p_oe;
    logic [19:0] p_addr, run_addr;
    logic [31:0] p_data, run_data;
    logic        run_bank, cur_bank;
    int          run_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            run_len = 0;
            p_ok    = 1'b0;
        end else begin
            if (!base_ram_ce_n) ce_b_cnt++;
            if (!ext_ram_ce_n)  ce_e_cnt++;
            if (ready)          ready_cnt++;
            chk("oe_n_high", {base_ram_oe_n, ext_ram_oe_n}, 2'b11);
            chk("one_bank_ce", base_ram_ce_n | ext_ram_ce_n, 1'b1);
            if (!bus_req) chk("no_strobe_without_req", {base_ram_ce_n, ext_ram_ce_n}, 2'b11);
            if (!base_ram_we_n || !ext_ram_we_n) begin
                cur_bank = !ext_ram_we_n;
                if (run_len == 0) begin
                    chk("setup_seen", p_ok, 1'b1);
                    chk("setup_ce", cur_bank ? p_cee : p_ceb, 1'b0);
                    chk("setup_we", cur_bank ? p_wee : p_web, 1'b1);
                    chk("setup_addr", p_addr, ram_addr);
                    chk("setup_data", p_data, ram_wdata);
                    chk("setup_oe", p_oe, 1'b1);
                    run_bank = cur_bank;
                    run_addr = ram_addr;
                    run_data = ram_wdata;
                end else begin
                    chk("we_bank_stable", cur_bank, run_bank);
                    chk("we_addr_stable", ram_addr, run_addr);
                    chk("we_data_stable", ram_wdata, run_data);
                end
                chk("we_ce", cur_bank ? ext_ram_ce_n : base_ram_ce_n, 1'b0);
                chk("we_be", ram_be_n, 4'h0);
                chk("we_oe", ram_wdata_oe, 1'b1);
                run_len++;
            end else if (run_len > 0) begin
                chk("we_len", run_len, WWC);
                chk("hold_ce", run_bank ? ext_ram_ce_n : base_ram_ce_n, 1'b0);
                chk("hold_addr", ram_addr, run_addr);
                chk("hold_data", ram_wdata, run_data);
                chk("hold_oe", ram_wdata_oe, 1'b1);
                got_q.push_back('{run_bank, run_addr, run_data});
                run_len = 0;
            end
            p_ok   = 1'b1;
            p_ceb  = base_ram_ce_n;
            p_web  = base_ram_we_n;
            p_cee  = ext_ram_ce_n;
            p_wee  = ext_ram_we_n;
            p_oe   = ram_wdata_oe;
            p_addr = ram_addr;
            p_data = ram_wdata;
        end
    end

    // Reference: word address of the line start, derived from the byte address arithmetically.
    function automatic logic [19:0] model_base(input logic [31:0] a);
        return 20'(((a % 32'h40_0000) / 16) * 4);
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge following the ready pulse.
    task automatic do_line(input logic [31:0] addr, input logic [127:0] line, input int gdelay,
                           input logic exp_bank, input logic [19:0] exp_base);
        int          acc;
        int          n;
        logic        seen;
        logic [19:0] ea;
        got_q.delete();
        ce_b_cnt  = 0;
        ce_e_cnt  = 0;
        ready_cnt = 0;
        wb_addr   = addr;
        wb_line   = line;
        wb_valid  = 1'b1;
        bus_grant = 1'b0;
        for (int d = 0; d < gdelay; d++) begin
            @(negedge clk);
            chk("grant_wait_req", bus_req, 1'b1);
            chk("grant_wait_ce", {base_ram_ce_n, ext_ram_ce_n}, 2'b11);
            @(posedge clk); #1;
        end
        bus_grant = 1'b1;
        acc = cyc;
        @(posedge clk); #1;
        wb_addr   = $urandom;
        wb_line   = {$urandom, $urandom, $urandom, $urandom};
        bus_grant = 1'($urandom_range(0, 1));
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if (ready) seen = 1'b1;
            else n++;
        end
        chk("ready_seen", seen, 1'b1);
        if (seen) chk("ready_latency", cyc - acc, LAT);
        wb_valid  = 1'b0;
        bus_grant = 1'b0;
        #1;
        chk("write_count", got_q.size(), WPL);
        for (int i = 0; i < WPL; i++) begin
            if (i < got_q.size()) begin
                ea = exp_base + 20'(i);
                chk("write_bank", got_q[i].bank, exp_bank);
                chk("write_addr", got_q[i].addr, ea);
                chk("write_data", got_q[i].data, line[32*i +: 32]);
            end
        end
        chk("sel_ce_cycles", exp_bank ? ce_e_cnt : ce_b_cnt, WPL * (WWC + 2));
        chk("other_ce_cycles", exp_bank ? ce_b_cnt : ce_e_cnt, 0);
        chk("ready_pulses", ready_cnt, 1);
        @(posedge clk); #1;
        if (!seen) begin
            rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
        end
    endtask

    vec_t        vecs[4];
    logic [31:0] ra;
    logic [127:0] rl;

    initial begin
        vecs[0] = '{32'h8000_0010, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 0, 1'b0, 20'h00004};
        vecs[1] = '{32'h8040_0000, {32'hDDDDDDDD, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA}, 5, 1'b1, 20'h00000};
        vecs[2] = '{32'h803F_FFFC, {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001}, 1, 1'b0, 20'hFFFFC};
        vecs[3] = '{32'h80C0_003F, {32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_0000, 32'h0000_FFFF}, 0, 1'b1, 20'h0000C};

        rst       = 1'b1;
        wb_valid  = 1'b0;
        bus_grant = 1'b0;
        wb_addr   = '0;
        wb_line   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ce", {base_ram_ce_n, ext_ram_ce_n}, 2'b11);
        chk("rst_we", {base_ram_we_n, ext_ram_we_n}, 2'b11);
        chk("rst_oe_n", {base_ram_oe_n, ext_ram_oe_n}, 2'b11);
        chk("rst_be", ram_be_n, 4'hF);
        chk("rst_wdata_oe", ram_wdata_oe, 1'b0);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_ready", ready, 1'b0);
        chk("rst_addr", ram_addr, 20'h0);
        chk("rst_wdata", ram_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            do_line(vecs[v].addr, vecs[v].line, vecs[v].gdelay, vecs[v].exp_bank, vecs[v].exp_base);
        end

        for (int r = 0; r < 8; r++) begin
            ra = $urandom;
            rl = {$urandom, $urandom, $urandom, $urandom};
            do_line(ra, rl, $urandom_range(0, 3), ra[22], model_base(ra));
        end

        // Reset mid-WRITE abandons the line without a ready pulse.
        wb_addr   = 32'h8000_0100;
        wb_line   = {4{32'h5A5A_5A5A}};
        wb_valid  = 1'b1;
        bus_grant = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_we_low", base_ram_we_n, 1'b0);
        @(posedge clk); #1;
        rst      = 1'b1;
        wb_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ce", {base_ram_ce_n, ext_ram_ce_n}, 2'b11);
        chk("midrst_we", {base_ram_we_n, ext_ram_we_n}, 2'b11);
        chk("midrst_bus_req", bus_req, 1'b0);
        chk("midrst_wdata_oe", ram_wdata_oe, 1'b0);
        chk("midrst_ready", ready, 1'b0);
        @(posedge clk); #1;
        rst       = 1'b0;
        bus_grant = 1'b0;
        ready_cnt = 0;
        ce_b_cnt  = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("midrst_no_ready", ready_cnt, 0);
        chk("midrst_no_strobe", ce_b_cnt, 0);

        do_line(32'h8000_0020, {32'h8, 32'h7, 32'h6, 32'h5}, 0, 1'b0, 20'h00008);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
